multicycle_main_fsm: RTL
========================

Name: multicycle_main_fsm

Overview:
- Multicycle successor to the single-cycle main decoder: a registered control FSM that sequences each RISC-V instruction through fetch, decode, execute, memory and writeback steps.
- Sits in the control unit beside the ALU decoder. It drives datapath mux selects and enables, and stalls on a valid/ready handshake with the data-cache memory system.
- Supports lw, sw, R-type, I-type ALU, beq-class branches and jal. lui/auipc are added by the optional feature.

Parameters:
- OPCODE_W, 7, opcode field width.
- RESULT_W, 2, width of ResultSrc / ALUSrcA / ALUSrcB selects.
- STATE_W, 4, state register width; must hold every state code.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- opcode  input  OPCODE_W  instruction opcode, valid from DECODE onward (IR already loaded).
- mem_ready  input  1  memory/cache completes the current request this cycle.
- mem_req  output  1  memory request valid.
- PCWrite  output  1  unconditional PC update.
- Branch  output  1  conditional PC update; datapath ANDs it with Zero.
- AdrSrc  output  1  0 selects PC, 1 selects ALU result as the memory address.
- MemWrite  output  1  request is a store.
- IRWrite  output  1  load instruction and OldPC registers.
- ResultSrc  output  RESULT_W  00 ALUOut, 01 Data, 10 ALUResult.
- ALUSrcA  output  RESULT_W  00 PC, 01 OldPC, 10 RD1.
- ALUSrcB  output  RESULT_W  00 RD2, 01 ImmExt, 10 constant 4.
- ImmSrc  output  3  000 I, 001 S, 010 B, 011 J, 100 U.
- ALUOp  output  2  00 add, 01 sub, 10 funct-decoded.
- RegWrite  output  1  register-file write.
- illegal_op  output  1  one-cycle pulse on an unrecognised opcode.

Behaviour:
- Reset:
  - rst high at a clk edge forces state to FETCH, from any state, including mid memory request.
  - A pending mem_ready in that cycle is ignored.
  - All outputs are registered-state decodes, so in reset state only the FETCH outputs are active.
- States and transitions:
  - FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. Holds while mem_ready=0. On mem_ready=1 that same cycle, IRWrite=1 and PCWrite=1, then go to DECODE. IRWrite and PCWrite are never asserted while waiting.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00, ImmSrc=010 (branch target precompute). Next state by opcode:
    - 0000011 or 0100011 to MEMADR.
    - 0110011 to EXECUTER.
    - 0010011 to EXECUTEI.
    - 1100011 to BEQ.
    - 1101111 to JAL.
    - Anything else: illegal_op=1, go to FETCH.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. ImmSrc=000 for a load, 001 for a store. Go to MEMREAD (load) or MEMWRITE (store).
  - MEMREAD: mem_req=1, AdrSrc=1, ResultSrc=00. Holds until mem_ready, then go to MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1, then go to FETCH.
  - MEMWRITE: mem_req=1, AdrSrc=1, MemWrite=1, ResultSrc=00. Holds until mem_ready, then go to FETCH.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10, then go to ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ImmSrc=000, ALUOp=10, then go to ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1, then go to FETCH.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, then go to FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1, then go to ALUWB.
- Defaults: every output not listed for a state is 0.
- Latency with zero wait states (FETCH cycle included): lw 5, sw 4, R/I 4, branch 3, jal 4. Each mem_ready=0 cycle adds one cycle.
- Handshake: mem_req stays high and the address and MemWrite stay stable until the mem_ready cycle. mem_ready while mem_req=0 is ignored.
- Opcode is sampled only in DECODE; changes in other states have no effect.
- State encodings outside the defined set recover to FETCH on the next edge.

Optional Feature:
- Macro UTYPE_LUI_AUIPC_EN.
- Defined:
  - DECODE routes 0110111 to LUI and 0010111 to AUIPC.
  - LUI: ImmSrc=100, ALUSrcB=01, ALUSrcA=10, ALUOp=11 (pass-B), then go to ALUWB.
  - AUIPC: ImmSrc=100, ALUSrcA=01, ALUSrcB=01, ALUOp=00, then go to ALUWB.
  - STATE_W must be at least 4.
- Undefined: both opcodes are illegal (illegal_op pulse, return to FETCH).

Decomposition:
- Package riscv_ctrl_pkg:
  - opcode localparams (OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL, OP_LUI, OP_AUIPC).
  - State encodings.
  - ImmSrc, ALUOp and select encodings.
- One sub-module, multicycle_fsm_outdec: a purely combinational state-to-control-word decode.
- The top level holds the state register, next-state logic and handshake gating.

Test Plan:
- Reset then lw (0000011) with mem_ready=1 always: state path FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH. RegWrite=1 and ResultSrc=01 only in cycle 5.
- sw (0100011) with mem_ready held low 3 cycles in MEMWRITE: mem_req=1, MemWrite=1, AdrSrc=1 held 4 cycles. Return to FETCH after mem_ready.
- FETCH with mem_ready=0 for 2 cycles: IRWrite=0 and PCWrite=0 while waiting. Both pulse for exactly 1 cycle on mem_ready.
- beq (1100011): Branch=1 and ALUOp=01 in cycle 3. jal (1101111): PCWrite=1 in the JAL state, then RegWrite=1 with ResultSrc=00.
- Opcode 1111111 in DECODE: illegal_op=1 for 1 cycle, next state FETCH. Also 0110111 with the macro undefined: same response.
- rst asserted during MEMREAD with mem_ready=1 in the same cycle: next state FETCH, RegWrite never asserted.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: opcodes, FSM state
// codes, datapath select codes and the packed control word.
package riscv_ctrl_pkg;

  localparam int OPC_W = 7;
  localparam int SEL_W = 2;
  localparam int IMM_W = 3;
  localparam int AOP_W = 2;
  localparam int ST_W  = 4;

  localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_ITYPE  = 7'b0010011;
  localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [ST_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11,
    S_AUIPC    = 4'd12
  } state_e;

  typedef enum logic [SEL_W-1:0] {
    RES_ALUOUT    = 2'b00,
    RES_DATA      = 2'b01,
    RES_ALURESULT = 2'b10
  } result_src_e;

  typedef enum logic [SEL_W-1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_RD1   = 2'b10
  } srca_e;

  typedef enum logic [SEL_W-1:0] {
    SRCB_RD2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } srcb_e;

  typedef enum logic [IMM_W-1:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  typedef enum logic [AOP_W-1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_PASSB = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic        mem_req;
    logic        pc_write;
    logic        branch;
    logic        adr_src;
    logic        mem_write;
    logic        ir_write;
    logic        reg_write;
    result_src_e result_src;
    srca_e       alu_src_a;
    srcb_e       alu_src_b;
    imm_src_e    imm_src;
    alu_op_e     alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{
    mem_req:    1'b0,
    pc_write:   1'b0,
    branch:     1'b0,
    adr_src:    1'b0,
    mem_write:  1'b0,
    ir_write:   1'b0,
    reg_write:  1'b0,
    result_src: RES_ALUOUT,
    alu_src_a:  SRCA_PC,
    alu_src_b:  SRCB_RD2,
    imm_src:    IMM_I,
    alu_op:     ALUOP_ADD
  };

endpackage

// File: rtl/multicycle_fsm_outdec.sv
// Combinational state-to-control-word decode for the multicycle control FSM.
// Optional lui/auipc states are decoded when UTYPE_LUI_AUIPC_EN is defined.
module multicycle_fsm_outdec
  import riscv_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic [STATE_W-1:0] state_i,
  input  logic               fetch_done_i,
  input  logic               store_i,
  output ctrl_t              ctrl_o
);

  always_comb begin
    ctrl_o = CTRL_IDLE;
    case (state_i)
      STATE_W'(S_FETCH): begin
        ctrl_o.mem_req    = 1'b1;
        ctrl_o.alu_src_a  = SRCA_PC;
        ctrl_o.alu_src_b  = SRCB_FOUR;
        ctrl_o.result_src = RES_ALURESULT;
        // IR/PC only update on the handshake cycle, never while stalled
        ctrl_o.ir_write   = fetch_done_i;
        ctrl_o.pc_write   = fetch_done_i;
      end
      STATE_W'(S_DECODE): begin
        ctrl_o.alu_src_a = SRCA_OLDPC;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.imm_src   = IMM_B;
      end
      STATE_W'(S_MEMADR): begin
        ctrl_o.alu_src_a = SRCA_RD1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.imm_src   = store_i ? IMM_S : IMM_I;
      end
      STATE_W'(S_MEMREAD): begin
        ctrl_o.mem_req = 1'b1;
        ctrl_o.adr_src = 1'b1;
      end
      STATE_W'(S_MEMWB): begin
        ctrl_o.result_src = RES_DATA;
        ctrl_o.reg_write  = 1'b1;
      end
      STATE_W'(S_MEMWRITE): begin
        ctrl_o.mem_req   = 1'b1;
        ctrl_o.adr_src   = 1'b1;
        ctrl_o.mem_write = 1'b1;
      end
      STATE_W'(S_EXECUTER): begin
        ctrl_o.alu_src_a = SRCA_RD1;
        ctrl_o.alu_src_b = SRCB_RD2;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      STATE_W'(S_EXECUTEI): begin
        ctrl_o.alu_src_a = SRCA_RD1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.imm_src   = IMM_I;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      STATE_W'(S_ALUWB): begin
        ctrl_o.reg_write = 1'b1;
      end
      STATE_W'(S_BEQ): begin
        ctrl_o.alu_src_a = SRCA_RD1;
        ctrl_o.alu_src_b = SRCB_RD2;
        ctrl_o.alu_op    = ALUOP_SUB;
        ctrl_o.branch    = 1'b1;
      end
      STATE_W'(S_JAL): begin
        ctrl_o.alu_src_a = SRCA_OLDPC;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.pc_write  = 1'b1;
      end
`ifdef UTYPE_LUI_AUIPC_EN
      STATE_W'(S_LUI): begin
        ctrl_o.alu_src_a = SRCA_RD1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.imm_src   = IMM_U;
        ctrl_o.alu_op    = ALUOP_PASSB;
      end
      STATE_W'(S_AUIPC): begin
        ctrl_o.alu_src_a = SRCA_OLDPC;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.imm_src   = IMM_U;
      end
`endif
      default: begin
        ctrl_o = CTRL_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_main_fsm.sv
// Multicycle RISC-V main control FSM: state register, next-state logic and
// memory handshake gating. Define UTYPE_LUI_AUIPC_EN to add lui/auipc support.
module multicycle_main_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 7,
  parameter int RESULT_W = 2,
  parameter int STATE_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                PCWrite,
  output logic                Branch,
  output logic                AdrSrc,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic [RESULT_W-1:0] ResultSrc,
  output logic [RESULT_W-1:0] ALUSrcA,
  output logic [RESULT_W-1:0] ALUSrcB,
  output logic [2:0]          ImmSrc,
  output logic [1:0]          ALUOp,
  output logic                RegWrite,
  output logic                illegal_op
);

  logic [STATE_W-1:0] state_q, state_d;
  logic               store_q, store_d;
  logic [OPC_W-1:0]   opc_s;
  logic               mem_done_s;
  logic               illegal_s;
  ctrl_t              ctrl_s;

  assign opc_s = OPC_W'(opcode);

  // A request completes only when it is actually being presented
  assign mem_done_s = ctrl_s.mem_req & mem_ready;

  multicycle_fsm_outdec #(
    .STATE_W(STATE_W)
  ) u_outdec (
    .state_i      (state_q),
    .fetch_done_i (mem_done_s),
    .store_i      (store_q),
    .ctrl_o       (ctrl_s)
  );

  // State register; store_q remembers the load/store class decoded in DECODE
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= STATE_W'(S_FETCH);
      store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
    end
  end

  // Next-state logic; unknown state codes fall back to FETCH
  always_comb begin
    state_d   = STATE_W'(S_FETCH);
    store_d   = store_q;
    illegal_s = 1'b0;
    case (state_q)
      STATE_W'(S_FETCH):
        state_d = mem_done_s ? STATE_W'(S_DECODE) : STATE_W'(S_FETCH);
      STATE_W'(S_DECODE): begin
        store_d = (opc_s == OP_STORE);
        case (opc_s)
          OP_LOAD:   state_d = STATE_W'(S_MEMADR);
          OP_STORE:  state_d = STATE_W'(S_MEMADR);
          OP_RTYPE:  state_d = STATE_W'(S_EXECUTER);
          OP_ITYPE:  state_d = STATE_W'(S_EXECUTEI);
          OP_BRANCH: state_d = STATE_W'(S_BEQ);
          OP_JAL:    state_d = STATE_W'(S_JAL);
`ifdef UTYPE_LUI_AUIPC_EN
          OP_LUI:    state_d = STATE_W'(S_LUI);
          OP_AUIPC:  state_d = STATE_W'(S_AUIPC);
`endif
          default: begin
            state_d   = STATE_W'(S_FETCH);
            illegal_s = 1'b1;
          end
        endcase
      end
      STATE_W'(S_MEMADR):
        state_d = store_q ? STATE_W'(S_MEMWRITE) : STATE_W'(S_MEMREAD);
      STATE_W'(S_MEMREAD):
        state_d = mem_done_s ? STATE_W'(S_MEMWB) : STATE_W'(S_MEMREAD);
      STATE_W'(S_MEMWB):
        state_d = STATE_W'(S_FETCH);
      STATE_W'(S_MEMWRITE):
        state_d = mem_done_s ? STATE_W'(S_FETCH) : STATE_W'(S_MEMWRITE);
      STATE_W'(S_EXECUTER):
        state_d = STATE_W'(S_ALUWB);
      STATE_W'(S_EXECUTEI):
        state_d = STATE_W'(S_ALUWB);
      STATE_W'(S_ALUWB):
        state_d = STATE_W'(S_FETCH);
      STATE_W'(S_BEQ):
        state_d = STATE_W'(S_FETCH);
      STATE_W'(S_JAL):
        state_d = STATE_W'(S_ALUWB);
`ifdef UTYPE_LUI_AUIPC_EN
      STATE_W'(S_LUI):
        state_d = STATE_W'(S_ALUWB);
      STATE_W'(S_AUIPC):
        state_d = STATE_W'(S_ALUWB);
`endif
      default:
        state_d = STATE_W'(S_FETCH);
    endcase
  end

  assign mem_req    = ctrl_s.mem_req;
  assign PCWrite    = ctrl_s.pc_write;
  assign Branch     = ctrl_s.branch;
  assign AdrSrc     = ctrl_s.adr_src;
  assign MemWrite   = ctrl_s.mem_write;
  assign IRWrite    = ctrl_s.ir_write;
  assign ResultSrc  = RESULT_W'(ctrl_s.result_src);
  assign ALUSrcA    = RESULT_W'(ctrl_s.alu_src_a);
  assign ALUSrcB    = RESULT_W'(ctrl_s.alu_src_b);
  assign ImmSrc     = ctrl_s.imm_src;
  assign ALUOp      = ctrl_s.alu_op;
  assign RegWrite   = ctrl_s.reg_write;
  assign illegal_op = illegal_s;

endmodule
